// File: rtl/shake_arb_pkg.sv
// shake_arb_pkg: shared state/mode types and round-robin pointer helper for shake_arbiter
package shake_arb_pkg;
  typedef enum logic [2:0] {IDLE, START, ABSORB, SQUEEZE, RELEASE} arb_state_t;
  typedef enum logic {SHAKE128 = 1'b0, SHAKE256 = 1'b1} shake_mode_t;
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 == n) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/shake_arbiter_rr.sv
// rr_arbiter: one-hot pick from req searching upward from ptr (from index 0 when SHAKE_ARB_FIXED_PRIO_EN)
module rr_arbiter import shake_arb_pkg::*; #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);
  logic [PW-1:0] base, pos;
  logic found;
`ifdef SHAKE_ARB_FIXED_PRIO_EN
  assign base = '0;
`else
  assign base = ptr;
`endif
  // first requester at or after base, wrapping around
  always_comb begin
    gnt = '0;
    idx = '0;
    pos = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      pos = PW'((int'(base) + i) % N);
      if (!found && req[pos]) begin
        gnt[pos] = 1'b1;
        idx = pos;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/shake_arbiter.sv
// shake_arbiter: whole-job arbiter sharing one SHAKE core; SHAKE_ARB_FIXED_PRIO_EN selects fixed priority
module shake_arbiter import shake_arb_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 64,
  parameter int LEN_W   = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_mode,
  input  logic [NUM_REQ*LEN_W-1:0]  req_outlen,
  output logic [NUM_REQ-1:0]        grant,
  input  logic [NUM_REQ*DATA_W-1:0] in_data,
  input  logic [NUM_REQ-1:0]        in_valid,
  input  logic [NUM_REQ-1:0]        in_last,
  output logic [NUM_REQ-1:0]        in_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [NUM_REQ-1:0]        out_valid,
  output logic                      out_last,
  input  logic [NUM_REQ-1:0]        out_ready,
  output logic                      core_start,
  output logic                      core_mode,
  output logic [LEN_W-1:0]          core_outlen,
  output logic [DATA_W-1:0]         core_in_data,
  output logic                      core_in_valid,
  output logic                      core_in_last,
  input  logic                      core_in_ready,
  input  logic [DATA_W-1:0]         core_out_data,
  input  logic                      core_out_valid,
  input  logic                      core_out_last,
  output logic                      core_out_ready
);
  localparam int PW = $clog2(NUM_REQ);
  arb_state_t state, nxt;
  shake_mode_t mode_q;
  logic [LEN_W-1:0] outlen_q;
  logic [PW-1:0] win, ptr, pick;
  logic [NUM_REQ-1:0] win_oh, pick_oh;
  logic act, absorb, squeeze;
  rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rr (
    .req(req),
    .ptr(ptr),
    .gnt(pick_oh),
    .idx(pick)
  );
  // controller state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  // job context captured once at grant time; later req_* changes are ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      win <= '0;
      win_oh <= '0;
      mode_q <= SHAKE128;
      outlen_q <= '0;
    end else if (state == IDLE && |req) begin
      win <= pick;
      win_oh <= pick_oh;
      mode_q <= shake_mode_t'(req_mode[pick]);
      outlen_q <= req_outlen[int'(pick)*LEN_W +: LEN_W];
    end
  end
`ifdef SHAKE_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  // search restarts just past the requester that was last served
  always_ff @(posedge clk) begin
    if (rst) ptr <= '0;
    else if (state == RELEASE) ptr <= PW'(rr_next(int'(win), NUM_REQ));
  end
`endif
  // job sequencing: one grant spans start, full absorb and full squeeze
  always_comb begin
    nxt = state == IDLE    ? (|req ? START : IDLE) :
          state == START   ? ABSORB :
          state == ABSORB  ? (core_in_valid & core_in_ready & core_in_last ? SQUEEZE : ABSORB) :
          state == SQUEEZE ? (core_out_valid & core_out_ready & core_out_last ? RELEASE : SQUEEZE) :
                             IDLE;
  end
  assign act            = state == START || state == ABSORB || state == SQUEEZE;
  assign absorb         = state == ABSORB;
  assign squeeze        = state == SQUEEZE;
  assign grant          = act ? win_oh : '0;
  assign core_start     = state == START;
  assign core_mode      = mode_q;
  assign core_outlen    = outlen_q;
  assign core_in_data   = in_data[int'(win)*DATA_W +: DATA_W];
  assign core_in_valid  = absorb & in_valid[win];
  assign core_in_last   = absorb & in_last[win];
  assign in_ready       = (absorb & core_in_ready) ? win_oh : '0;
  assign out_data       = core_out_data;
  assign out_valid      = (squeeze & core_out_valid) ? win_oh : '0;
  assign out_last       = squeeze & core_out_last;
  assign core_out_ready = squeeze & out_ready[win];
endmodule

// File: tb/tb_shake_arbiter.sv
// tb_shake_arbiter: randomized/directed bench with a job-level reference model for shake_arbiter
module tb_shake_arbiter;
  localparam int NR = 4, DW = 64, LW = 32;
  logic clk = 1'b0, rst;
  logic [NR-1:0] req, req_mode, grant, in_valid, in_last, in_ready, out_valid, out_ready;
  logic [NR*LW-1:0] req_outlen;
  logic [NR*DW-1:0] in_data;
  logic [DW-1:0] out_data, core_in_data, core_out_data;
  logic out_last, core_start, core_mode, core_in_valid, core_in_last, core_in_ready;
  logic core_out_valid, core_out_last, core_out_ready;
  logic [LW-1:0] core_outlen;
  always #5 clk = ~clk;
  shake_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_mode(req_mode), .req_outlen(req_outlen),
    .grant(grant), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .core_start(core_start), .core_mode(core_mode),
    .core_outlen(core_outlen), .core_in_data(core_in_data), .core_in_valid(core_in_valid),
    .core_in_last(core_in_last), .core_in_ready(core_in_ready), .core_out_data(core_out_data),
    .core_out_valid(core_out_valid), .core_out_last(core_out_last), .core_out_ready(core_out_ready)
  );
  int passed = 0, failed = 0, total = 0;
  int cyc = 0, free_from = 0, ptr_m = 0, cur = 0, job_ol = 0, rx = 0;
  int in_cnt = 0, out_cnt = 0, start_cnt = 0;
  bit busy_m = 0, job_mode = 0, rst_prev = 0, rst_req = 0;
  logic [NR-1:0] req_prev = '0, mode_prev = '0;
  logic [NR*LW-1:0] ol_prev = '0;
  logic [63:0] srcq [NR][$];
  int ol_r [NR];
  bit md_r [NR], has_job [NR];
  int jobs_left [NR];
  int order [$];
  bit cphase = 0, tog = 0;
  int ck = 0, cnout = 0;
  logic [63:0] cseed = '0;
  int cin_mode = 0, stall = 0, stall_set = 0;
  bit vrand = 0, orand = 0, covrand = 0, drop_mode = 0, scramble = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic int pick_m(input logic [NR-1:0] r, input int p);
    int s;
`ifdef SHAKE_ARB_FIXED_PRIO_EN
    s = 0;
`else
    s = p;
`endif
    for (int i = 0; i < NR; i++) if (r[(s + i) % NR]) return (s + i) % NR;
    return 0;
  endfunction
  task automatic load_job(input int r, input int n, input int ol);
    srcq[r].delete();
    for (int i = 0; i < n; i++) srcq[r].push_back({$urandom, $urandom});
    ol_r[r] = ol;
    md_r[r] = 1'($urandom % 2);
    has_job[r] = 1;
  endtask
  task automatic load_rand(input int r);
    load_job(r, 1 + int'($urandom % 3), 8 * (1 + int'($urandom % 5)));
  endtask
  task automatic drive();
    rst = rst_req;
    for (int r = 0; r < NR; r++) begin
      req[r] = has_job[r] && !(drop_mode && busy_m && cur == r);
      in_valid[r] = srcq[r].size() > 0 && (!vrand || $urandom % 2 == 1);
      in_data[r*DW +: DW] = srcq[r].size() > 0 ? srcq[r][0] : '0;
      in_last[r] = srcq[r].size() == 1;
      req_mode[r] = md_r[r];
      req_outlen[r*LW +: LW] = LW'(ol_r[r]);
      if (scramble && busy_m && cur == r) begin
        req_mode[r] = 1'($urandom % 2);
        req_outlen[r*LW +: LW] = $urandom;
      end
      out_ready[r] = !(busy_m && cur == r && stall > 0) && (!orand || $urandom % 2 == 1);
    end
    tog = ~tog;
    core_in_ready = cin_mode == 0 ? 1'b1 : cin_mode == 1 ? tog : 1'($urandom % 2);
    core_out_valid = cphase && (!covrand || $urandom % 2 == 1);
    core_out_data = cseed + 64'(ck);
    core_out_last = cphase && ck == cnout - 1;
  endtask
  task automatic settle();
    logic [NR-1:0] exp_g;
    bit rising, rh, ch;
    if (rst) begin
      busy_m = 0; cphase = 0; ptr_m = 0; stall = 0; free_from = cyc + 1; rst_prev = 1;
      for (int r = 0; r < NR; r++) begin
        srcq[r].delete(); has_job[r] = 0; jobs_left[r] = 0;
      end
      req_prev = req; ol_prev = req_outlen; mode_prev = req_mode;
      return;
    end
    if (rst_prev) begin
      chk("rst_core_mode", core_mode, 0);
      chk("rst_core_outlen", core_outlen, 0);
    end
    rising = 0;
    if (!busy_m && cyc - 1 >= free_from && |req_prev) begin
      cur = pick_m(req_prev, ptr_m);
      busy_m = 1; rising = 1; rx = 0; stall = stall_set;
      job_ol = int'(ol_prev[cur*LW +: LW]);
      job_mode = mode_prev[cur];
    end
    exp_g = '0;
    if (busy_m) exp_g[cur] = 1'b1;
    chk("grant", grant, exp_g);
    chk("core_start", core_start, rising);
    chk("iso_in_ready", in_ready & ~exp_g, 0);
    chk("iso_out_valid", out_valid & ~exp_g, 0);
    if (core_start) start_cnt++;
    if (rising) chk("start_in_ready", in_ready, 0);
    if (busy_m) begin
      chk("core_mode", core_mode, job_mode);
      chk("core_outlen", core_outlen, job_ol);
    end else begin
      chk("idle_core_in_valid", core_in_valid, 0);
      chk("idle_core_out_ready", core_out_ready, 0);
    end
    rh = busy_m && in_valid[cur] && in_ready[cur];
    ch = core_in_valid && core_in_ready;
    chk("in_handshake", ch, rh);
    if (rh) begin
      chk("in_data", core_in_data, srcq[cur][0]);
      chk("in_last", core_in_last, srcq[cur].size() == 1);
      void'(srcq[cur].pop_front());
      in_cnt++;
    end
    if (ch && core_in_last) begin
      cphase = 1; ck = 0; cnout = (int'(core_outlen) + 7) / 8; cseed = {$urandom, $urandom};
    end
    rh = busy_m && out_valid[cur] && out_ready[cur];
    ch = core_out_valid && core_out_ready;
    chk("out_handshake", ch, rh);
    if (busy_m && out_valid[cur] && stall > 0) stall--;
    if (rh) begin
      chk("out_data", out_data, cseed + 64'(ck));
      rx++; out_cnt++;
      if (out_last) begin
        chk("out_word_count", rx, (job_ol + 7) / 8);
        busy_m = 0; free_from = cyc + 2; ptr_m = (cur + 1) % NR;
        order.push_back(cur);
        has_job[cur] = 0;
        if (jobs_left[cur] > 0) begin
          jobs_left[cur]--;
          load_rand(cur);
        end
      end
    end
    if (ch) begin
      ck++;
      if (ck == cnout) cphase = 0;
    end
    req_prev = req; ol_prev = req_outlen; mode_prev = req_mode; rst_prev = 0;
  endtask
  task automatic step();
    @(posedge clk);
    cyc++;
    #1 drive();
    #1 settle();
  endtask
  function automatic bit pending();
    bit p = busy_m;
    for (int r = 0; r < NR; r++) p |= has_job[r];
    return p;
  endfunction
  task automatic run_idle(input string tag, input int maxc);
    int t = 0;
    while (pending() && t < maxc) begin
      step();
      t++;
    end
    chk(tag, t < maxc, 1);
  endtask
  task automatic do_reset();
    rst_req = 1;
    step();
    rst_req = 0;
  endtask
  initial begin
    #1_000_000;
    $fatal(1, "FAIL watchdog: simulation did not finish");
  end
  initial begin
    for (int r = 0; r < NR; r++) begin
      ol_r[r] = 0; md_r[r] = 0; has_job[r] = 0; jobs_left[r] = 0;
    end
    rst_req = 1;
    drive();
    step();
    do_reset();
    step();
    chk("reset_grant", grant, 0);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_core_start", core_start, 0);
    in_cnt = 0; out_cnt = 0; start_cnt = 0;
    load_job(2, 3, 32);
    step();
    step();
    chk("single_grant", grant, 4'b0100);
    run_idle("single_timeout", 200);
    chk("single_in_words", in_cnt, 3);
    chk("single_out_words", out_cnt, 4);
    chk("single_starts", start_cnt, 1);
    do_reset();
    order.delete();
    for (int r = 0; r < NR; r++) begin
      load_rand(r);
      jobs_left[r] = 3;
    end
    run_idle("contention_timeout", 3000);
    chk("contention_jobs", order.size(), 16);
    for (int i = 0; i < 4; i++) begin
`ifdef SHAKE_ARB_FIXED_PRIO_EN
      chk("contention_order", order.size() > i ? order[i] : -1, 0);
`else
      chk("contention_order", order.size() > i ? order[i] : -1, i);
`endif
    end
    cin_mode = 1; stall_set = 5; in_cnt = 0; out_cnt = 0;
    load_job(1, 4, 40);
    run_idle("backpressure_timeout", 300);
    chk("bp_in_words", in_cnt, 4);
    chk("bp_out_words", out_cnt, 5);
    cin_mode = 0; stall_set = 0;
    do_reset();
    drop_mode = 1; order.delete();
    load_job(0, 3, 24);
    load_job(1, 2, 16);
    run_idle("drop_timeout", 300);
    chk("drop_first", order.size() > 0 ? order[0] : -1, 0);
    drop_mode = 0;
    vrand = 1; orand = 1; covrand = 1; cin_mode = 2; scramble = 1;
    for (int k = 0; k < 12; k++) begin
      stall_set = int'($urandom % 4);
      drop_mode = 1'($urandom % 2);
      for (int r = 0; r < NR; r++) if ($urandom % 3 != 0) begin
        load_rand(r);
        jobs_left[r] = int'($urandom % 3);
      end
      run_idle("random_timeout", 4000);
    end
    vrand = 0; orand = 0; covrand = 0; cin_mode = 0; scramble = 0; drop_mode = 0; stall_set = 0;
    load_job(1, 2, 32);
    begin
      int t = 0;
      while (out_valid == '0 && t < 200) begin
        step();
        t++;
      end
      chk("wait_squeeze", t < 200, 1);
    end
    do_reset();
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_core_start", core_start, 0);
    load_job(3, 1, 8);
    step();
    chk("post_rst_idle_grant", grant, 0);
    step();
    chk("post_rst_grant", grant, 4'b1000);
    run_idle("post_rst_timeout", 200);
    step();
    step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
